// File: rtl/seg_scan_display.sv
// Eight-digit multiplexed seven-segment driver. Hex values load directly; decimal
// values go through a 32-step double-dabble conversion. Scanning never stops.
module seg_scan_display #(
  parameter int SCAN_DIV  = 100000,
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 load,
  input  logic                 dec_mode,
  output logic                 busy,
  output logic                 ovf,
  output logic [7:0]           an,
  output logic [7:0]           seg
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t               state, state_nxt;
  logic [DATA_BITS-1:0] bin_q;
  logic [39:0]          bcd_q;
  logic [39:0]          bcd_shift;
  logic [4:0]           step_q;
  logic [31:0]          disp_q;
  logic                 ovf_q;
  logic [CNT_W-1:0]     scan_q;
  logic [2:0]           idx_q;
  logic [3:0]           nib;
  logic                 last_step;

  // Nibbles are adjusted independently; a nibble never carries into its neighbour.
  function automatic logic [39:0] add3_all(input logic [39:0] v);
    logic [39:0] r;
    r = v;
    for (int i = 0; i < 10; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign last_step = (step_q == 5'd31);
  assign bcd_shift = (add3_all(bcd_q) << 1) | {39'd0, bin_q[DATA_BITS-1]};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path through
  // the block leaves it unassigned and a latch can never be inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (load && dec_mode) state_nxt = CONV;
      CONV: if (last_step)        state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CONV);
    ovf  = ovf_q;
    an   = ~(8'h01 << idx_q);
    nib  = disp_q[{idx_q, 2'b00} +: 4];
    seg  = 8'hFF;
    case (nib)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      4'hF: seg = 8'h8E;
      default: seg = 8'hFF;
    endcase
  end

  // Display register only changes on a hex load or on the final conversion step,
  // so a reset mid-conversion discards the partial BCD result.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      step_q <= '0;
      disp_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load && dec_mode) begin
            bin_q  <= data_in;
            bcd_q  <= '0;
            step_q <= '0;
          end else if (load) begin
            disp_q <= data_in;
            ovf_q  <= 1'b0;
          end
        end
        CONV: begin
          bin_q  <= bin_q << 1;
          bcd_q  <= bcd_shift;
          step_q <= step_q + 5'd1;
          if (last_step) begin
            disp_q <= bcd_shift[31:0];
            ovf_q  <= |bcd_shift[39:32];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_q <= '0;
      idx_q  <= '0;
    end else if (scan_q == SCAN_LAST) begin
      scan_q <= '0;
      idx_q  <= idx_q + 3'd1;
    end else begin
      scan_q <= scan_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display: reads the display back through the
// scanned an/seg outputs and compares with hand-computed values.
module tb_seg_scan_display;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic        load;
  logic        dec_mode;
  logic        busy;
  logic        ovf;
  logic [7:0]  an;
  logic [7:0]  seg;

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  seg_scan_display #(.SCAN_DIV(4), .DATA_BITS(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .load     (load),
    .dec_mode (dec_mode),
    .busy     (busy),
    .ovf      (ovf),
    .an       (an),
    .seg      (seg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Walks the scan until all eight digits have been seen and rebuilds the word.
  task automatic read_disp(output logic [31:0] val, output bit ok);
    bit [7:0]   seen;
    int         d;
    bit         hit;
    logic [3:0] n;
    val  = '0;
    seen = '0;
    ok   = 1'b1;
    n    = '0;
    for (int c = 0; c < 40 && seen != 8'hFF; c++) begin
      d = -1;
      for (int i = 0; i < 8; i++) if (an == ~(8'h01 << i)) d = i;
      hit = 1'b0;
      for (int k = 0; k < 16; k++) if (seg == seg_tab[k]) begin n = k[3:0]; hit = 1'b1; end
      if (d < 0 || !hit) ok = 1'b0;
      else begin
        val[4*d +: 4] = n;
        seen[d] = 1'b1;
      end
      step();
    end
    if (seen != 8'hFF) ok = 1'b0;
  endtask

  task automatic expect_disp(input string tag, input logic [31:0] exp);
    logic [31:0] v;
    bit          ok;
    read_disp(v, ok);
    check({tag, "_scan_ok"}, 64'(ok), 64'd1);
    check({tag, "_disp"}, 64'(v), 64'(exp));
  endtask

  task automatic expect_digit0(input string tag, input logic [7:0] exp);
    int c = 0;
    while (an != 8'hFE && c < 40) begin step(); c++; end
    check({tag, "_an0"}, 64'(an), 64'hFE);
    check({tag, "_seg0"}, 64'(seg), 64'(exp));
  endtask

  task automatic hex_load(input logic [31:0] v);
    data_in = v; dec_mode = 1'b0; load = 1'b1;
    step();
    load = 1'b0; data_in = '0;
  endtask

  // Decimal load; optionally pokes a stray load inj_at cycles into CONV.
  task automatic run_conv(input logic [31:0] v, input int inj_at, output int cycles);
    data_in = v; dec_mode = 1'b1; load = 1'b1;
    step();
    load = 1'b0; dec_mode = 1'b0; data_in = '0;
    cycles = 0;
    while (busy && cycles < 40) begin
      if (cycles == inj_at) begin load = 1'b1; dec_mode = 1'b1; data_in = 32'hFFFF_FFFF; end
      step();
      load = 1'b0; dec_mode = 1'b0; data_in = '0;
      cycles++;
    end
  endtask

  initial begin
    int cyc;

    // Reset wins over a simultaneous load.
    rst = 1'b1; load = 1'b1; dec_mode = 1'b0; data_in = 32'hFFFF_FFFF;
    step();
    load = 1'b0; data_in = '0;
    check("rst_an", 64'(an), 64'hFE);
    check("rst_seg", 64'(seg), 64'hC0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    step();
    rst = 1'b0;

    // Scan order and hold time.
    rst = 1'b1; step(); rst = 1'b0;
    for (int j = 0; j < 36; j++) begin
      logic [7:0] exp_an;
      exp_an = ~(8'h01 << ((j / 4) % 8));
      check("scan_an", 64'(an), 64'(exp_an));
      step();
    end

    // Hex load.
    rst = 1'b1; step(); rst = 1'b0;
    hex_load(32'h1234_ABCD);
    check("hex_an", 64'(an), 64'hFE);
    check("hex_seg", 64'(seg), 64'hA1);
    check("hex_ovf", 64'(ovf), 64'd0);
    check("hex_busy", 64'(busy), 64'd0);
    expect_disp("hex", 32'h1234_ABCD);

    // Decimal 12345678.
    run_conv(32'h00BC_614E, -1, cyc);
    check("dec_busy_cycles", 64'(cyc), 64'd32);
    check("dec_ovf", 64'(ovf), 64'd0);
    expect_disp("dec", 32'h1234_5678);
    expect_digit0("dec", 8'h80);

    // Largest value that still fits in eight digits.
    run_conv(32'h05F5_E0FF, -1, cyc);
    check("max8_ovf", 64'(ovf), 64'd0);
    expect_disp("max8", 32'h9999_9999);

    // 100000000 overflows, then a hex load clears ovf.
    run_conv(32'h05F5_E100, -1, cyc);
    check("ovf_set", 64'(ovf), 64'd1);
    expect_disp("ovf", 32'h0000_0000);
    hex_load(32'h0000_0005);
    check("ovf_clr", 64'(ovf), 64'd0);
    expect_digit0("hex5", 8'h92);

    // All-ones converts to 4294967295.
    run_conv(32'hFFFF_FFFF, -1, cyc);
    check("ffff_ovf", 64'(ovf), 64'd1);
    expect_disp("ffff", 32'h9496_7295);

    // A load during CONV is ignored.
    run_conv(32'd42, 10, cyc);
    check("ign_busy_cycles", 64'(cyc), 64'd32);
    expect_disp("ign", 32'h0000_0042);

    // Reset mid-conversion discards the partial result.
    hex_load(32'h0000_ABCD);
    data_in = 32'hFFFF_FFFF; dec_mode = 1'b1; load = 1'b1;
    step();
    load = 1'b0; dec_mode = 1'b0; data_in = '0;
    for (int i = 0; i < 20; i++) step();
    check("abort_busy_pre", 64'(busy), 64'd1);
    rst = 1'b1; step(); rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_an", 64'(an), 64'hFE);
    check("abort_seg", 64'(seg), 64'hC0);
    expect_disp("abort", 32'h0000_0000);
    run_conv(32'd7, -1, cyc);
    check("seven_busy_cycles", 64'(cyc), 64'd32);
    expect_disp("seven", 32'h0000_0007);
    expect_digit0("seven", 8'hF8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
